// File: rtl/falu_pkg.sv
// Shared definitions for the FP ALU issue sequencer: unit codes, FSM states,
// flag constants and the unit-code decode helpers.
package falu_pkg;

  localparam int NUM_UNITS = 5;
  localparam int FLAG_W    = 5;

  // Flag order is {NV, DZ, OF, UF, NX}
  localparam logic [FLAG_W-1:0] FLAG_NV = 5'b10000;

  localparam logic [2:0] FALU_ADD = 3'd0;
  localparam logic [2:0] FALU_MUL = 3'd1;
  localparam logic [2:0] FALU_DIV = 3'd2;
  localparam logic [2:0] FALU_CMP = 3'd3;
  localparam logic [2:0] FALU_CVT = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2,
    ST_RESP   = 2'd3
  } falu_state_t;

  function automatic logic falu_legal(input logic [2:0] code);
    falu_legal = (int'(code) < NUM_UNITS);
  endfunction

  function automatic logic [NUM_UNITS-1:0] falu_decode(input logic [2:0] code);
    falu_decode = '0;
    if (falu_legal(code)) falu_decode = NUM_UNITS'(1) << code;
  endfunction

endpackage

// File: rtl/falu_if.sv
// Issue / unit / response bundle between the execute stage, the FP units and
// the sequencer. The slave modport is the sequencer's view.
interface falu_if #(parameter int DATA_W = 32);
  import falu_pkg::*;

  // Valid/ready: a transfer happens on a rising edge where both are high; once
  // valid is raised, the payload stays stable and valid stays high until then.
  logic                        issue_valid;
  logic                        issue_ready;
  logic [2:0]                  falu_ctrl;
  logic [NUM_UNITS-1:0]        unit_sel;
  logic [NUM_UNITS-1:0]        unit_start;
  logic [NUM_UNITS-1:0]        unit_done;
  logic [NUM_UNITS*DATA_W-1:0] unit_result;
  logic [NUM_UNITS*FLAG_W-1:0] unit_flags;
  logic                        res_valid;
  logic                        res_ready;
  logic [DATA_W-1:0]           result;
  logic [FLAG_W-1:0]           flags;
  logic                        res_illegal;
  logic                        res_timeout;
  logic                        falu_stall;

  modport slave (
    input  issue_valid, falu_ctrl, unit_done, unit_result, unit_flags, res_ready,
    output issue_ready, unit_sel, unit_start, res_valid, result, flags,
           res_illegal, res_timeout, falu_stall
  );

  modport master (
    output issue_valid, falu_ctrl, unit_done, unit_result, unit_flags, res_ready,
    input  issue_ready, unit_sel, unit_start, res_valid, result, flags,
           res_illegal, res_timeout, falu_stall
  );

endinterface

// File: rtl/falu_result_mux.sv
// One-hot selection of a unit's result and flags; zero when nothing is selected.
module falu_result_mux
  import falu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [NUM_UNITS-1:0]        sel,
  input  logic [NUM_UNITS*DATA_W-1:0] unit_result,
  input  logic [NUM_UNITS*FLAG_W-1:0] unit_flags,
  output logic [DATA_W-1:0]           result,
  output logic [FLAG_W-1:0]           flags
);

  always_comb begin
    result = '0;
    flags  = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (sel[i]) begin
        result = result | unit_result[i*DATA_W +: DATA_W];
        flags  = flags  | unit_flags[i*FLAG_W +: FLAG_W];
      end
    end
  end

endmodule

// File: rtl/falu_sequencer.sv
// Multi-cycle issue controller for the FP ALU: decode, launch, wait, respond.
// Define FALU_TIMEOUT_EN to add a watchdog that ends a stuck operation after TIMEOUT_CYC cycles.
module falu_sequencer
  import falu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        CLK,
  input  logic        rst,
  falu_if.slave       bus,
  output falu_state_t state_dbg
);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  falu_state_t          state_q, state_d;
  logic [NUM_UNITS-1:0] sel_q, sel_d;
  logic [DATA_W-1:0]    result_q, result_d;
  logic [FLAG_W-1:0]    flags_q, flags_d;
  logic                 illegal_q, illegal_d;
  logic                 timeout_q, timeout_d;

  logic [DATA_W-1:0]    mux_result;
  logic [FLAG_W-1:0]    mux_flags;
  logic                 done_sel;
  logic                 timeout_hit;

  falu_result_mux #(.DATA_W(DATA_W)) u_mux (
    .sel         (sel_q),
    .unit_result (bus.unit_result),
    .unit_flags  (bus.unit_flags),
    .result      (mux_result),
    .flags       (mux_flags)
  );

  // Only the held selection can complete an operation; strays are masked here.
  assign done_sel = |(bus.unit_done & sel_q);

`ifdef FALU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q;

  // IDLE always precedes LAUNCH, so clearing in IDLE means LAUNCH starts at zero.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst)                                           cnt_q <= '0;
    else if (state_q == ST_IDLE)                       cnt_q <= '0;
    else if (state_q == ST_LAUNCH || state_q == ST_BUSY) cnt_q <= cnt_q + 1'b1;
  end

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    result_d  = result_q;
    flags_d   = flags_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.issue_valid) begin
          if (falu_legal(bus.falu_ctrl)) begin
            state_d = ST_LAUNCH;
            sel_d   = falu_decode(bus.falu_ctrl);
          end else begin
            state_d   = ST_RESP;
            illegal_d = 1'b1;
            result_d  = '0;
            flags_d   = FLAG_NV;
          end
        end
      end
      ST_LAUNCH, ST_BUSY: begin
        if (done_sel) begin
          state_d  = ST_RESP;
          result_d = mux_result;
          flags_d  = mux_flags;
        end else if (timeout_hit) begin
          state_d   = ST_RESP;
          timeout_d = 1'b1;
          result_d  = '0;
          flags_d   = '0;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_RESP: begin
        if (bus.res_ready) begin
          state_d   = ST_IDLE;
          sel_d     = '0;
          result_d  = '0;
          flags_d   = '0;
          illegal_d = 1'b0;
          timeout_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.issue_ready = (state_q == ST_IDLE);
  assign bus.unit_sel    = sel_q;
  assign bus.unit_start  = (state_q == ST_LAUNCH) ? sel_q : '0;
  assign bus.res_valid   = (state_q == ST_RESP);
  assign bus.result      = result_q;
  assign bus.flags       = flags_q;
  assign bus.res_illegal = illegal_q;
  assign bus.res_timeout = timeout_q;
  assign bus.falu_stall  = (state_q != ST_IDLE) | (bus.issue_valid & (state_q == ST_IDLE));
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_falu_sequencer.sv
// Directed + randomized bench for falu_sequencer with a latency/response model
// and an expected-result queue.
module tb_falu_sequencer;
  import falu_pkg::*;

  localparam int DW = 32;
  localparam int NU = 5;
  localparam int FW = 5;
  localparam int TO = 8;
`ifdef FALU_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        rst;
  falu_state_t state_dbg;

  falu_if #(.DATA_W(DW)) bus ();

  falu_sequencer #(.DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .CLK       (CLK),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic noise();
    bus.unit_result = {$urandom, $urandom, $urandom, $urandom, $urandom};
    bus.unit_flags  = (NU*FW)'($urandom);
  endtask

  task automatic idle_inputs();
    bus.issue_valid = 1'b0;
    bus.falu_ctrl   = 3'd0;
    bus.unit_done   = '0;
    bus.res_ready   = 1'b0;
    noise();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"}, bus.issue_ready, 1);
    check({tag, "_valid"}, bus.res_valid, 0);
    check({tag, "_sel"},   bus.unit_sel, 0);
    check({tag, "_start"}, bus.unit_start, 0);
    check({tag, "_stall"}, bus.falu_stall, 0);
    check({tag, "_res"},   bus.result, 0);
    check({tag, "_flags"}, bus.flags, 0);
    check({tag, "_ill"},   bus.res_illegal, 0);
    check({tag, "_tmo"},   bus.res_timeout, 0);
  endtask

  // delay: cycles after the start pulse before the unit reports done.
  task automatic run_op(input logic [2:0] code, input int delay, input int hold,
                        input logic [NU-1:0] stray_mask);
    logic          legal;
    logic          tmo;
    logic [NU-1:0] oh;
    logic [DW-1:0] r, exp_r;
    logic [FW-1:0] f, exp_f;
    int            lat;
    legal = (code < 3'd5);
    oh    = legal ? (NU'(1) << code) : '0;
    r     = $urandom;
    f     = FW'($urandom_range(0, 31));
    tmo   = legal && TO_EN && (delay + 1 > TO);
    lat   = !legal ? 1 : (tmo ? 1 + TO : 2 + delay);
    exp_q.push_back((legal && !tmo) ? r : '0);
    exp_f = !legal ? 5'b10000 : (tmo ? 5'b00000 : f);

    @(negedge CLK);
    noise();
    bus.issue_valid = 1'b1;
    bus.falu_ctrl   = code;
    #1;
    check("issue_ready", bus.issue_ready, 1);
    check("stall_req", bus.falu_stall, 1);
    @(posedge CLK);
    for (int k = 1; k <= lat; k++) begin
      @(negedge CLK);
      noise();
      bus.issue_valid = 1'b0;
      bus.falu_ctrl   = 3'($urandom);
      bus.unit_done   = '0;
      bus.res_ready   = (k < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (legal && k < lat) bus.unit_done = stray_mask | (NU'($urandom) & ~oh);
      if (legal && k == 1 + delay) begin
        bus.unit_done = bus.unit_done | oh;
        bus.unit_result[code*DW +: DW] = r;
        bus.unit_flags[code*FW +: FW]  = f;
      end
      #1;
      check("res_valid", bus.res_valid, (k == lat));
      check("unit_start", bus.unit_start, (k == 1) ? oh : '0);
      check("unit_sel", bus.unit_sel, oh);
      check("busy_ready", bus.issue_ready, 0);
      check("busy_stall", bus.falu_stall, 1);
    end
    exp_r = exp_q.pop_front();
    check("result", bus.result, exp_r);
    check("flags", bus.flags, exp_f);
    check("illegal", bus.res_illegal, !legal);
    check("timeout", bus.res_timeout, tmo);
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      noise();
      bus.res_ready = 1'b0;
      bus.unit_done = NU'($urandom) | oh;
      #1;
      check("hold_valid", bus.res_valid, 1);
      check("hold_result", bus.result, exp_r);
      check("hold_flags", bus.flags, exp_f);
    end
    @(negedge CLK);
    bus.unit_done = '0;
    bus.res_ready = 1'b1;
    #1;
    check("accept_valid", bus.res_valid, 1);
    @(posedge CLK);
    #1;
    check("ret_valid", bus.res_valid, 0);
    check("ret_ready", bus.issue_ready, 1);
    check("ret_sel", bus.unit_sel, 0);
    check("ret_stall", bus.falu_stall, 0);
    @(negedge CLK);
    bus.res_ready = 1'($urandom_range(0, 1));
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #1;
    check_quiet("rst");
    check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
    repeat (2) @(negedge CLK);
    rst = 1'b0;

    // Done pulses and Res_Ready while idle change nothing
    bus.unit_done = '1;
    bus.res_ready = 1'b1;
    @(negedge CLK);
    bus.unit_done = '0;
    bus.res_ready = 1'b0;
    #1;
    check_quiet("idle");

    run_op(FALU_ADD, 0, 0, '0);
    run_op(FALU_DIV, 10, 1, '0);
    run_op(3'b110, 0, 2, '0);
    run_op(FALU_MUL, 4, 5, 5'b01000);
    run_op(FALU_CVT, 20, 0, '0);
    run_op(FALU_CMP, 7, 0, '0);

    for (int i = 0; i < 25; i++)
      run_op(3'($urandom_range(0, 7)), $urandom_range(0, 6), $urandom_range(0, 3), '0);

    // Abort a divide in BUSY with an asynchronous reset
    @(negedge CLK);
    idle_inputs();
    bus.issue_valid = 1'b1;
    bus.falu_ctrl   = FALU_DIV;
    @(negedge CLK);
    bus.issue_valid = 1'b0;
    repeat (3) @(negedge CLK);
    check("pre_rst_state", 64'(state_dbg), 64'(ST_BUSY));
    #2;
    rst = 1'b1;
    #1;
    check_quiet("abort");
    @(negedge CLK);
    rst = 1'b0;
    bus.unit_done = 5'b00100;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      bus.unit_done = '0;
      #1;
      check("post_rst_valid", bus.res_valid, 0);
      check("post_rst_ready", bus.issue_ready, 1);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/falu_sequencer.md
# falu_sequencer

Multi-cycle issue controller for the floating-point ALU. It accepts one FP operation at a time from the execute stage and decodes `FALU_Ctrl` to a one-hot unit select. It launches the selected unit (add/sub, mul, div, compare, convert), waits for that unit's done, and captures the result and exception flags. It then holds them on a valid/ready response port and stalls the integer pipeline for the whole operation.

## Interface
- `DATA_W`, 32: operand/result width.
- `NUM_UNITS`, 5: number of FP execution units; bit i of select corresponds to `FALU_Ctrl` == i.
- `FLAG_W`, 5: IEEE exception flag width (NV, DZ, OF, UF, NX).
- `TIMEOUT_CYC`, 64: watchdog limit in cycles; used only with `FALU_TIMEOUT_EN`.

- `CLK` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `Issue_Valid` in 1: operation request.
- `Issue_Ready` out 1: sequencer can accept.
- `FALU_Ctrl` in 3: unit code: 000 add/sub, 001 mul, 010 div, 011 compare, 100 convert, 101–111 illegal.
- `Unit_Sel` out NUM_UNITS: one-hot select, held for the whole operation.
- `Unit_Start` out NUM_UNITS: one-cycle one-hot launch pulse.
- `Unit_Done` in NUM_UNITS: per-unit completion, one cycle, result valid same cycle.
- `Unit_Result` in NUM_UNITS*DATA_W: flattened unit results, unit i at [i*DATA_W +: DATA_W].
- `Unit_Flags` in NUM_UNITS*FLAG_W: flattened flags.
- `Res_Valid` out 1; `Res_Ready` in 1: response handshake.
- `Result` out DATA_W; `Flags` out FLAG_W.
- `Res_Illegal` out 1: response is for an illegal code.
- `Res_Timeout` out 1: response produced by watchdog.
- `FALU_Stall` out 1: pipeline stall.

## Operation
- FSM states: IDLE, LAUNCH, BUSY, RESP.
- IDLE:
  - `Issue_Ready`=1.
  - On `Issue_Valid`, register the code.
  - Legal code → LAUNCH. Illegal code → RESP with `Res_Illegal`=1, `Result`=0, `Flags`=NV (5'b10000), and no unit selected.
- LAUNCH (1 cycle):
  - `Unit_Start`=`Unit_Sel`.
  - If the selected unit's `Unit_Done` is high this cycle, capture and go to RESP; otherwise → BUSY.
- BUSY: wait for the selected unit's done; capture its result and flags; → RESP.
- Done from unselected units is ignored in every state.
- Done from the selected unit in IDLE or RESP is ignored.
- RESP:
  - `Res_Valid`=1; `Result`, `Flags` and the status bits stay stable until `Res_Valid`&`Res_Ready`, then → IDLE.
  - Back-to-back operation needs a new issue in IDLE; there is no issue overlap.
- `FALU_Stall` = (state != IDLE) | (`Issue_Valid` & IDLE).
- `Unit_Sel` is zero in IDLE, held constant from LAUNCH through RESP, and cleared on return to IDLE.

## Timing
- Reset values: state IDLE; `Issue_Ready`=1; all other outputs 0.
- Reset mid-operation aborts immediately. The FP units share `rst` and must also clear. No response is produced.
- Latency from accept edge to `Res_Valid`:
  - 2 cycles minimum (unit done during LAUNCH).
  - 2 + N cycles for a unit asserting done N cycles after start.
  - 1 cycle for illegal codes.
- Response is registered; no combinational path from `Unit_Done` to `Res_Valid`.
- `Res_Ready` high while not in RESP has no effect.

## Configuration
- `FALU_TIMEOUT_EN` defined:
  - A counter counts cycles in LAUNCH+BUSY.
  - On reaching `TIMEOUT_CYC` without done, the FSM goes to RESP with `Res_Timeout`=1, `Result`=0 and `Flags`=0.
  - The counter clears on entry to LAUNCH.
- `FALU_TIMEOUT_EN` undefined: no counter; the FSM waits indefinitely; `Res_Timeout` is tied 0.

## Structure
- Shared package `falu_pkg`: `FALU_Ctrl` code constants, the FSM state typedef, `FLAG_W` and the NV flag constant, `NUM_UNITS`.
- One sub-module, `falu_result_mux`: combinational one-hot selection of `Unit_Result`/`Unit_Flags` by `Unit_Sel`, output 0 when no bit is set.

## Test plan
- Add: issue `FALU_Ctrl`=000, unit 0 done in LAUNCH with result 0x3F800000 → `Unit_Start`=00001 for one cycle; `Res_Valid` 2 cycles after accept; `Result`=0x3F800000.
- Div: issue 010, done 10 cycles after start → `FALU_Stall` high for the whole operation; `Res_Valid` at accept+12; `Issue_Ready`=0 throughout.
- Illegal: issue 110 → no `Unit_Start`; at accept+1 `Res_Valid`=1, `Res_Illegal`=1, `Flags`=10000.
- Backpressure and stray done: hold `Res_Ready`=0 for 5 cycles; pulse done on unit 3 while mul is selected → `Result` stable and unchanged; ignored done has no effect.
- Reset: assert `rst` in BUSY → all outputs 0 and `Issue_Ready`=1 asynchronously; no response after release.
- With `FALU_TIMEOUT_EN`, `TIMEOUT_CYC`=8, no done → RESP after 8 cycles with `Res_Timeout`=1 and `Result`=0.
